regfile_writeback: RTL and testbench

- Write side of the integer register file: accepts retiring results from the ALU path and the load path, buffers them in program order, and commits one result per cycle into the 32x32 register array.
- Also provides the two combinational read ports used by the instruction decoder.
- Pending, uncommitted results are forwarded onto those read ports, so the decoder always sees architecturally current values.

---
 rtl/regfile_writeback_pkg.sv | 17 +
 rtl/regfile_writeback_wb_queue.sv | 80 ++++++++
 rtl/regfile_writeback.sv | 124 ++++++++++++
 tb/tb_regfile_writeback.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the integer register-file writeback slice.
//   XLEN       : register / result data width
//   REG_ADDR_W : register address width
//   NUM_REGS   : number of architectural integer registers
//   wb_entry_t : one pending writeback (destination register + result)
package regfile_writeback_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_wb_queue.sv
// wb_queue: DEPTH-entry circular buffer of pending writebacks.
// Two ordered push ports (push0 is older than push1 when both fire), one pop
// port at the head. The whole entry array, a per-slot valid mask, the head
// pointer and the occupancy are exposed so the owner can forward results.
//   clk, reset     : clock, async active-low reset
//   push0_valid/_entry, push1_valid/_entry : enqueue requests (already gated)
//   pop            : dequeue head entry (caller guarantees count != 0)
//   entries        : raw storage, indexed by slot
//   valid_mask     : slot holds a live entry
//   head           : slot of the oldest entry
//   count          : occupied entries
module wb_queue
  import regfile_writeback_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push0_valid,
  input  wb_entry_t        push0_entry,
  input  logic             push1_valid,
  input  wb_entry_t        push1_entry,
  input  logic             pop,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid_mask,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W:0]   count
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] push1_idx;
  logic [PTR_W-1:0] offs;

  always_comb begin
    mem_d = mem_q;
    // push1 lands right behind push0 when both fire, else at the tail itself
    push1_idx = tail_q + PTR_W'(push0_valid);
    if (push0_valid) mem_d[tail_q]    = push0_entry;
    if (push1_valid) mem_d[push1_idx] = push1_entry;
    tail_d  = tail_q + PTR_W'(push0_valid) + PTR_W'(push1_valid);
    head_d  = head_q + PTR_W'(pop);
    count_d = count_q + (PTR_W+1)'(push0_valid) + (PTR_W+1)'(push1_valid)
              - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A slot is live when its distance from head is below the occupancy;
  // DEPTH is a power of two so the PTR_W-bit subtraction wraps correctly.
  always_comb begin
    valid_mask = '0;
    offs       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs          = PTR_W'(i) - head_q;
      valid_mask[i] = ({1'b0, offs} < count_q);
    end
  end

  assign entries = mem_q;
  assign head    = head_q;
  assign count   = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: write side and read ports of the integer register file.
// Retiring load and ALU results are queued in program order (load older when
// both arrive together) and committed one per cycle into a 32 x XLEN array.
// The two decoder read ports forward from queued, uncommitted entries.
//   clk, reset                 : clock, async active-low reset
//   ld_valid/ld_rd/ld_data     : load result offered
//   alu_valid/alu_rd/alu_data  : ALU result offered
//   wb_ready                   : >= 2 free queue slots, both sources may push
//   rs1/rs2, read_data1/2      : combinational read ports with forwarding
//   commit_valid/commit_rd     : register write performed on the last edge
//   pending_cnt                : queued entries
module regfile_writeback #(
  parameter  int XLEN  = regfile_writeback_pkg::XLEN,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            wb_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            commit_valid,
  output logic [4:0]      commit_rd,
  output logic [PTR_W:0]  pending_cnt
);

  localparam int NUM_REGS = regfile_writeback_pkg::NUM_REGS;
  typedef regfile_writeback_pkg::wb_entry_t entry_t;

  logic [XLEN-1:0]  regs_q [NUM_REGS];
  logic [XLEN-1:0]  regs_d [NUM_REGS];
  logic             commit_valid_q, commit_valid_d;
  logic [4:0]       commit_rd_q, commit_rd_d;

  entry_t           q_entries [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PTR_W-1:0] q_head;
  logic [PTR_W:0]   q_count;
  entry_t           ld_entry, alu_entry, head_entry;
  logic             ld_push, alu_push, pop;
  logic [PTR_W-1:0] fwd_idx;

  assign wb_ready = (q_count <= (PTR_W+1)'(DEPTH - 2));

  // Writes to x0 are architectural no-ops, so they never take a slot.
  assign ld_push   = ld_valid  && wb_ready && (ld_rd  != 5'd0);
  assign alu_push  = alu_valid && wb_ready && (alu_rd != 5'd0);
  assign ld_entry  = '{rd: ld_rd,  data: ld_data};
  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign pop       = (q_count != '0);

  wb_queue #(.DEPTH(DEPTH)) u_wb_queue (
    .clk         (clk),
    .reset       (reset),
    .push0_valid (ld_push),
    .push0_entry (ld_entry),
    .push1_valid (alu_push),
    .push1_entry (alu_entry),
    .pop         (pop),
    .entries     (q_entries),
    .valid_mask  (q_valid),
    .head        (q_head),
    .count       (q_count)
  );

  assign head_entry = q_entries[q_head];

  always_comb begin
    regs_d         = regs_q;
    commit_valid_d = pop;
    commit_rd_d    = '0;
    if (pop) begin
      commit_rd_d = head_entry.rd;
      if (head_entry.rd != 5'd0) regs_d[head_entry.rd] = head_entry.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
    end else begin
      regs_q         <= regs_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
    end
  end

  // Scan oldest to youngest so a later (younger) match overrides.
  always_comb begin
    read_data1 = regs_q[rs1];
    read_data2 = regs_q[rs2];
    fwd_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = q_head + PTR_W'(k);
      if (q_valid[fwd_idx]) begin
        if (q_entries[fwd_idx].rd == rs1) read_data1 = q_entries[fwd_idx].data;
        if (q_entries[fwd_idx].rd == rs2) read_data2 = q_entries[fwd_idx].data;
      end
    end
    if (rs1 == 5'd0) read_data1 = '0;
    if (rs2 == 5'd0) read_data2 = '0;
  end

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign pending_cnt  = q_count;

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!reset)
    !((ld_valid || alu_valid) && !wb_ready));

  a_x0_zero : assert property (@(posedge clk) disable iff (!reset)
    regs_q[0] == '0);

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, alu_valid;
  logic [4:0]  ld_rd, alu_rd, rs1, rs2;
  logic [31:0] ld_data, alu_data;
  logic        wb_ready, commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] read_data1, read_data2;
  logic [2:0]  pending_cnt;

  int checks   = 0;
  int failures = 0;

  regfile_writeback #(.XLEN(32), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_valid     (ld_valid),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .wb_ready     (wb_ready),
    .rs1          (rs1),
    .rs2          (rs2),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .pending_cnt  (pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld_v;
    logic [4:0]  ld_rd;
    logic [31:0] ld_d;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ecv;
    logic [4:0]  ecrd;
    logic [2:0]  ecnt;
    logic        erdy;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic av, logic [4:0] ard, logic [31:0] ad,
                              logic [4:0] r1, logic [4:0] r2,
                              logic [31:0] e1, logic [31:0] e2,
                              logic ecv, logic [4:0] ecrd,
                              logic [2:0] ecnt, logic erdy);
    vec_t v;
    v.ld_v = lv;  v.ld_rd = lrd;  v.ld_d = ld;
    v.alu_v = av; v.alu_rd = ard; v.alu_d = ad;
    v.rs1 = r1;   v.rs2 = r2;     v.e1 = e1; v.e2 = e2;
    v.ecv = ecv;  v.ecrd = ecrd;  v.ecnt = ecnt; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
  endtask

  initial begin
    // ld: v rd data | alu: v rd data | rs1 rs2 | exp rd1 rd2 cv crd cnt rdy
    vecs[0]  = mk(0, 0, 0,     1, 3, 32'hDEADBEEF, 3, 0, 32'hDEADBEEF, 0, 0, 0, 1, 1);
    vecs[1]  = mk(0, 0, 0,     0, 0, 0,            3, 5, 32'hDEADBEEF, 0, 1, 3, 0, 1);
    vecs[2]  = mk(1, 7, 32'h11, 1, 7, 32'h22,      7, 3, 32'h22, 32'hDEADBEEF, 0, 0, 2, 1);
    vecs[3]  = mk(0, 0, 0,     0, 0, 0,            7, 3, 32'h22, 32'hDEADBEEF, 1, 7, 1, 1);
    vecs[4]  = mk(0, 0, 0,     0, 0, 0,            7, 3, 32'h22, 32'hDEADBEEF, 1, 7, 0, 1);
    vecs[5]  = mk(0, 0, 0,     1, 0, 32'hFFFFFFFF, 0, 7, 0, 32'h22, 0, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0,     0, 0, 0,            0, 7, 0, 32'h22, 0, 0, 0, 1);
    vecs[7]  = mk(1, 1, 32'hA1, 1, 2, 32'hA2,      1, 2, 32'hA1, 32'hA2, 0, 0, 2, 1);
    vecs[8]  = mk(1, 4, 32'hB4, 1, 5, 32'hB5,      4, 5, 32'hB4, 32'hB5, 1, 1, 3, 0);
    vecs[9]  = mk(0, 0, 0,     0, 0, 0,            1, 2, 32'hA1, 32'hA2, 1, 2, 2, 1);
    vecs[10] = mk(0, 0, 0,     1, 6, 32'hC6,       6, 4, 32'hC6, 32'hB4, 1, 4, 2, 1);
    vecs[11] = mk(0, 0, 0,     1, 8, 32'hC8,       8, 5, 32'hC8, 32'hB5, 1, 5, 2, 1);
    vecs[12] = mk(0, 0, 0,     1, 6, 32'hD6,       6, 8, 32'hD6, 32'hC8, 1, 6, 2, 1);
    vecs[13] = mk(0, 0, 0,     0, 0, 0,            6, 8, 32'hD6, 32'hC8, 1, 8, 1, 1);
    vecs[14] = mk(0, 0, 0,     0, 0, 0,            6, 3, 32'hD6, 32'hDEADBEEF, 1, 6, 0, 1);
    vecs[15] = mk(0, 0, 0,     0, 0, 0,            6, 3, 32'hD6, 32'hDEADBEEF, 0, 0, 0, 1);

    reset = 1'b0;
    drive_idle();
    rs1 = 5'd5; rs2 = 5'd31;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_rd1", read_data1, 0);
    chk("reset_rd2", read_data2, 0);
    chk("reset_cnt", 32'(pending_cnt), 0);
    chk("reset_ready", 32'(wb_ready), 1);
    chk("reset_cv", 32'(commit_valid), 0);
    chk("reset_crd", 32'(commit_rd), 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ld_valid  = vecs[i].ld_v;  ld_rd  = vecs[i].ld_rd;  ld_data  = vecs[i].ld_d;
      alu_valid = vecs[i].alu_v; alu_rd = vecs[i].alu_rd; alu_data = vecs[i].alu_d;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rd1", i), read_data1, vecs[i].e1);
      chk($sformatf("v%0d_rd2", i), read_data2, vecs[i].e2);
      chk($sformatf("v%0d_cv", i), 32'(commit_valid), 32'(vecs[i].ecv));
      if (vecs[i].ecv) chk($sformatf("v%0d_crd", i), 32'(commit_rd), 32'(vecs[i].ecrd));
      chk($sformatf("v%0d_cnt", i), 32'(pending_cnt), 32'(vecs[i].ecnt));
      chk($sformatf("v%0d_ready", i), 32'(wb_ready), 32'(vecs[i].erdy));
    end

    // Reset with three entries pending.
    @(negedge clk);
    ld_valid = 1; ld_rd = 10; ld_data = 32'h10;
    alu_valid = 1; alu_rd = 11; alu_data = 32'h1111;
    @(posedge clk); #1;
    chk("mr_cnt2", 32'(pending_cnt), 2);
    @(negedge clk);
    ld_valid = 1; ld_rd = 12; ld_data = 32'h12;
    alu_valid = 1; alu_rd = 13; alu_data = 32'h13;
    @(posedge clk); #1;
    chk("mr_cnt3", 32'(pending_cnt), 3);
    chk("mr_commit10", 32'(commit_rd), 10);
    @(negedge clk);
    drive_idle();
    rs1 = 10; rs2 = 3;
    #2 reset = 1'b0;
    #1;
    chk("mr_async_cnt", 32'(pending_cnt), 0);
    chk("mr_async_cv", 32'(commit_valid), 0);
    chk("mr_async_ready", 32'(wb_ready), 1);
    chk("mr_reg10", read_data1, 0);
    chk("mr_reg3", read_data2, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mr_hold_cv", 32'(commit_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    rs1 = 9; rs2 = 13;
    @(posedge clk); #1;
    chk("post_fwd9", read_data1, 32'h99);
    chk("post_reg13", read_data2, 0);
    chk("post_cnt1", 32'(pending_cnt), 1);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    chk("post_cv", 32'(commit_valid), 1);
    chk("post_crd", 32'(commit_rd), 9);
    chk("post_cnt0", 32'(pending_cnt), 0);
    chk("post_reg9", read_data1, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
